pll_reset_sequencer: RTL and testbench

//   Sequences an iCE40 SB_PLL40 instance and gates the downstream system reset on PLL lock.

---
 rtl/pll_reset_sequencer_pkg.sv | 19 +
 rtl/pll_reset_sequencer_sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encodings and sizing helper for the PLL reset sequencer.
// Encodings are visible on the debug state port, so they must not be renumbered.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser; reset clears both stages so an async
// input is re-qualified from scratch after every reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives SB_PLL40 RESETB, qualifies LOCK, and holds the PLL-domain system
// reset until lock has been continuously stable; retries, then faults.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 12000,
  parameter int STABLE_CYCLES    = 1200,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             fault_q, fault_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_s;
  logic             fail;

  sync_2ff u_lock_sync (
    .clk_i (clock_in),
    .rst_i (reset),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    fail        = 1'b0;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q >= RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q >= LOCK_LAST) begin
          fail = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q >= STAB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d     = ST_RESET_PLL;
          lock_lost_d = 1'b1;
          retry_d     = '0;
        end
      end
      ST_FAULT: cnt_d = '0;
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // A failed attempt either burns one retry or exhausts the budget.
    if (fail) begin
      cnt_d = '0;
      if (retry_q >= RETRY_MAX) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RESET_PLL;
        retry_d = retry_q + 4'd1;
      end
    end

    if (restart) begin
      state_d     = ST_RESET_PLL;
      cnt_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end

    // Outputs follow the next state so they line up with the visible state.
    pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE) ||
                   (state_d == ST_RUN);
    sys_reset_d  = (state_d != ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset   = sys_reset_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scenarios push cycle-stamped expectations into a scoreboard;
// an independent monitor compares outputs when each stamped cycle arrives.
module tb_pll_reset_sequencer;

  localparam int RST_PULSE = 4;
  localparam int LOCK_TO   = 20;
  localparam int STAB      = 8;
  localparam int RETRIES   = 2;

  localparam int S_RST = 0, S_WAIT = 1, S_STAB = 2, S_RUN = 3, S_FAULT = 4;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES (RST_PULSE),
    .LOCK_TIMEOUT     (LOCK_TO),
    .STABLE_CYCLES    (STAB),
    .MAX_RETRIES      (RETRIES)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .locked      (locked),
    .restart     (restart),
    .pll_resetb  (pll_resetb),
    .sys_reset   (sys_reset),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [10:0] exp;
    logic [10:0] msk;
  } chk_t;

  chk_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   base   = 0;

  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_SR  = 11'b000_0100_0000;

  function automatic logic [10:0] pk(int st, bit prb, bit sr, bit f, bit ll, int rc);
    return {3'(st), prb, sr, f, ll, 4'(rc)};
  endfunction

  task automatic exp_all(int k, string nm, int st, bit prb, bit sr, bit f, bit ll, int rc);
    chk_t c;
    c.cyc = base + k; c.nm = nm; c.exp = pk(st, prb, sr, f, ll, rc); c.msk = M_ALL;
    sb.push_back(c);
  endtask

  task automatic exp_sr(int k, string nm, bit sr);
    chk_t c;
    c.cyc = base + k; c.nm = nm; c.exp = pk(0, 0, sr, 0, 0, 0); c.msk = M_SR;
    sb.push_back(c);
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    logic [10:0] obs;
    forever begin
      @(negedge clk);
      #1;
      obs = {state, pll_resetb, sys_reset, fault, lock_lost, retry_count};
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_chk++;
          if ((obs & sb[i].msk) !== (sb[i].exp & sb[i].msk)) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got {st,prb,sr,f,ll,rc}=%b required %b (mask %b)",
                     sb[i].nm, cyc - base, obs & sb[i].msk, sb[i].exp & sb[i].msk, sb[i].msk);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic to_cyc(int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; locked = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = cyc;
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; restart = 1'b0;

    // Clean lock, then lock loss in RUN and re-lock.
    do_reset();
    exp_all(0,  "reset_vals",     S_RST,  0, 1, 0, 0, 0);
    exp_all(3,  "rst_pulse_end",  S_RST,  0, 1, 0, 0, 0);
    exp_all(4,  "resetb_rise",    S_WAIT, 1, 1, 0, 0, 0);
    exp_all(8,  "sync_latency",   S_WAIT, 1, 1, 0, 0, 0);
    exp_all(9,  "stab_enter",     S_STAB, 1, 1, 0, 0, 0);
    exp_all(16, "stab_last",      S_STAB, 1, 1, 0, 0, 0);
    exp_all(17, "run_release",    S_RUN,  1, 0, 0, 0, 0);
    exp_all(22, "run_pre_loss",   S_RUN,  1, 0, 0, 0, 0);
    exp_all(23, "lock_lost_puls", S_RST,  0, 1, 0, 1, 0);
    exp_all(24, "lock_lost_one",  S_RST,  0, 1, 0, 0, 0);
    exp_all(27, "relock_wait",    S_WAIT, 1, 1, 0, 0, 0);
    exp_all(28, "relock_stab",    S_STAB, 1, 1, 0, 0, 0);
    exp_all(35, "relock_stab_end",S_STAB, 1, 1, 0, 0, 0);
    exp_all(36, "relock_run",     S_RUN,  1, 0, 0, 0, 0);
    to_cyc(6);  locked = 1'b1;
    to_cyc(20); locked = 1'b0;
    to_cyc(24); locked = 1'b1;
    to_cyc(38);

    // No lock: three attempts, fault, then restart with lock present.
    do_reset();
    exp_all(23,  "try1_last",     S_WAIT,  1, 1, 0, 0, 0);
    exp_all(24,  "try2_begin",    S_RST,   0, 1, 0, 0, 1);
    exp_all(28,  "try2_wait",     S_WAIT,  1, 1, 0, 0, 1);
    exp_all(47,  "try2_last",     S_WAIT,  1, 1, 0, 0, 1);
    exp_all(48,  "try3_begin",    S_RST,   0, 1, 0, 0, 2);
    exp_all(71,  "try3_last",     S_WAIT,  1, 1, 0, 0, 2);
    exp_all(72,  "fault_enter",   S_FAULT, 0, 1, 1, 0, 2);
    exp_all(150, "fault_hold",    S_FAULT, 0, 1, 1, 0, 2);
    exp_all(272, "fault_200",     S_FAULT, 0, 1, 1, 0, 2);
    exp_all(280, "fault_pre_rst", S_FAULT, 0, 1, 1, 0, 2);
    exp_all(281, "restart_clear", S_RST,   0, 1, 0, 0, 0);
    exp_all(285, "restart_wait",  S_WAIT,  1, 1, 0, 0, 0);
    exp_all(286, "restart_stab",  S_STAB,  1, 1, 0, 0, 0);
    exp_all(294, "restart_run",   S_RUN,   1, 0, 0, 0, 0);
    to_cyc(280); restart = 1'b1; locked = 1'b1;
    to_cyc(281); restart = 1'b0;
    to_cyc(296);

    // One-cycle glitch in STABILIZE at cnt=5; sys_reset must never drop early.
    do_reset();
    for (int k = 1; k <= 27; k++) exp_sr(k, "glitch_sr_held", 1'b1);
    exp_all(14, "glitch_seen",    S_STAB, 1, 1, 0, 0, 0);
    exp_all(15, "glitch_retry",   S_RST,  0, 1, 0, 0, 1);
    exp_all(19, "glitch_wait",    S_WAIT, 1, 1, 0, 0, 1);
    exp_all(20, "glitch_stab",    S_STAB, 1, 1, 0, 0, 1);
    exp_all(28, "glitch_run",     S_RUN,  1, 0, 0, 0, 0);
    to_cyc(6);  locked = 1'b1;
    to_cyc(12); locked = 1'b0;
    to_cyc(13); locked = 1'b1;
    to_cyc(30);

    // Reset (together with restart) during STABILIZE.
    do_reset();
    exp_all(11, "midop_stab",     S_STAB, 1, 1, 0, 0, 0);
    exp_all(12, "midop_reset",    S_RST,  0, 1, 0, 0, 0);
    exp_all(13, "midop_held",     S_RST,  0, 1, 0, 0, 0);
    exp_all(17, "midop_wait",     S_WAIT, 1, 1, 0, 0, 0);
    exp_all(18, "midop_stab2",    S_STAB, 1, 1, 0, 0, 0);
    exp_all(25, "midop_stab_end", S_STAB, 1, 1, 0, 0, 0);
    exp_all(26, "midop_run",      S_RUN,  1, 0, 0, 0, 0);
    to_cyc(6);  locked = 1'b1;
    to_cyc(11); reset = 1'b1; restart = 1'b1;
    to_cyc(13); reset = 1'b0; restart = 1'b0;
    to_cyc(30);

    repeat (2) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
